// File: rtl/tile_buf_pkg.sv
// rtl/tile_buf_pkg.sv - shared types and sizing helpers for the tile ping-pong staging path
package tile_buf_pkg;

    // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam int OUT_FIFO_DEPTH = 2;

    function automatic int words_per_tile(input int tile_w, input int tile_h, input int pix_per_clk);
        return (tile_w * tile_h) / pix_per_clk;
    endfunction

    function automatic int addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/tile_buffer_bank.sv
// rtl/tile_buffer_bank.sv - one tile of word storage, single write port, registered read port
//
// Ports:
//   clk            clock
//   wr_en/waddr/wdata   write port, word written at posedge
//   rd_en/raddr    read request; rdata is valid the cycle after rd_en
//   rdata          registered read data
module tile_buffer_bank #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 128,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    // Contents deliberately have no reset: a reset discards tiles logically
    // through the controller's state, not by scrubbing storage.
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tile_pingpong_ctrl.sv
// rtl/tile_pingpong_ctrl.sv - double-buffered tile staging between DMA writes and the window engine
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   dma_valid/dma_ready/dma_data    DMA word stream in, raster order within a tile
//   out_valid/out_ready/out_data    tile word stream out, out_last on word WORDS-1
//   bank_full[1:0]                  bank holds a complete undrained tile
//   tile_done                       pulse on the pop of a tile's last word
module tile_pingpong_ctrl
    import tile_buf_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TILE_W      = 32,
    parameter int TILE_H      = 32,
    parameter int PIX_PER_CLK = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dma_valid,
    output logic                          dma_ready,
    input  logic [DATA_W*PIX_PER_CLK-1:0] dma_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W*PIX_PER_CLK-1:0] out_data,
    output logic                          out_last,
    output logic [1:0]                    bank_full,
    output logic                          tile_done
);

    localparam int WORD_W = DATA_W * PIX_PER_CLK;
    localparam int WORDS  = words_per_tile(TILE_W, TILE_H, PIX_PER_CLK);
    localparam int AW     = addr_w(WORDS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    bank_state_e       state [2];
    logic              wsel, rsel;
    logic [AW-1:0]     wcnt, rcnt;

    // One read is in flight for a cycle while the bank's registered port returns it.
    logic              inflight, inflight_last, inflight_bank;

    logic [WORD_W-1:0] fifo_data [OUT_FIFO_DEPTH];
    logic              fifo_last [OUT_FIFO_DEPTH];
    logic              fifo_wptr, fifo_rptr;
    logic [1:0]        fifo_cnt;

    logic              wr_fire, rd_issue, pop;
    logic [1:0]        occupancy;
    logic [WORD_W-1:0] rdata [2];

    assign dma_ready = rst_n && (state[wsel] == EMPTY || state[wsel] == FILLING);
    assign wr_fire   = dma_valid && dma_ready;

    assign out_valid = rst_n && (fifo_cnt != 2'd0);
    assign out_data  = out_valid ? fifo_data[fifo_rptr] : '0;
    assign out_last  = out_valid && fifo_last[fifo_rptr];
    assign pop       = out_valid && out_ready;
    assign tile_done = pop && out_last;

    assign bank_full[0] = rst_n && (state[0] == FULL || state[0] == DRAINING);
    assign bank_full[1] = rst_n && (state[1] == FULL || state[1] == DRAINING);

    // Words already queued or on their way, after this cycle's pop; issuing
    // only while this is below the FIFO depth guarantees a free slot on return.
    assign occupancy = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    assign rd_issue  = rst_n && (state[rsel] == FULL || state[rsel] == DRAINING)
                       && (occupancy < 2'(OUT_FIFO_DEPTH));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tile_buffer_bank #(
            .WORD_W (WORD_W),
            .DEPTH  (WORDS),
            .AW     (AW)
        ) u_bank (
            .clk    (clk),
            .wr_en  (wr_fire && (wsel == 1'(b))),
            .waddr  (wcnt),
            .wdata  (dma_data),
            .rd_en  (rd_issue && (rsel == 1'(b))),
            .raddr  (rcnt),
            .rdata  (rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state[0]      <= EMPTY;
            state[1]      <= EMPTY;
            wsel          <= 1'b0;
            rsel          <= 1'b0;
            wcnt          <= '0;
            rcnt          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_bank <= 1'b0;
            fifo_wptr     <= 1'b0;
            fifo_rptr     <= 1'b0;
            fifo_cnt      <= 2'd0;
        end else begin
            // A bank is either on the write side or the read side, never both,
            // so fill-complete of one and free of the other can land together.
            for (int b = 0; b < 2; b++) begin
                if (wr_fire && wsel == 1'(b)) begin
                    state[b] <= (wcnt == LAST_ADDR) ? FULL : FILLING;
                end else if (rd_issue && rsel == 1'(b)) begin
                    state[b] <= (rcnt == LAST_ADDR) ? EMPTY : DRAINING;
                end
            end

            if (wr_fire) begin
                if (wcnt == LAST_ADDR) begin
                    wcnt <= '0;
                    wsel <= ~wsel;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end

            if (rd_issue) begin
                if (rcnt == LAST_ADDR) begin
                    rcnt <= '0;
                    rsel <= ~rsel;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end

            inflight      <= rd_issue;
            inflight_last <= rd_issue && (rcnt == LAST_ADDR);
            inflight_bank <= rsel;

            if (inflight) begin
                fifo_data[fifo_wptr] <= rdata[inflight_bank];
                fifo_last[fifo_wptr] <= inflight_last;
                fifo_wptr            <= ~fifo_wptr;
            end
            if (pop) begin
                fifo_rptr <= ~fifo_rptr;
            end
            case ({inflight, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
